// File: rtl/development_stage_tracker_if.sv
// Command/status bundle for development_stage_tracker.
// master: drives the level commands (inc/dec/fast/setval/set_level/freeze)
//         and observes the registered status (level/stage/stage_changed/stage_up).
// slave : the tracker itself, receiving commands and driving status.
interface development_stage_tracker_if #(
  parameter int LEVEL_W = 9,
  parameter int STAGE_W = 2
);
  logic               inc;
  logic               dec;
  logic               fast;
  logic               setval;
  logic [LEVEL_W-1:0] set_level;
  logic               freeze;
  logic [LEVEL_W-1:0] level;
  logic [STAGE_W-1:0] stage;
  logic               stage_changed;
  logic               stage_up;

  modport master (
    output inc, dec, fast, setval, set_level, freeze,
    input  level, stage, stage_changed, stage_up
  );

  modport slave (
    input  inc, dec, fast, setval, set_level, freeze,
    output level, stage, stage_changed, stage_up
  );
endinterface

// File: rtl/development_stage_tracker.sv
// Saturating level accumulator with a derived stage (top STAGE_W bits of the
// level range), demotion hysteresis and a minimum dwell between stage changes.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the
//   commands inc/dec/fast/setval/set_level/freeze and the registered status
//   level/stage/stage_changed/stage_up.
// The interface instance must be built with the same LEVEL_W/STAGE_W.
module development_stage_tracker #(
  parameter int LEVEL_W   = 9,
  parameter int STAGE_W   = 2,
  parameter int FAST_STEP = 2,
  parameter int HYST      = 8,
  parameter int DWELL     = 4,
  parameter int MONOTONIC = 0
) (
  input logic                        clk,
  input logic                        rst,
  development_stage_tracker_if.slave bus
);
  localparam int SEG_W = LEVEL_W - STAGE_W;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [STAGE_W-1:0] STAGE_MAX = '1;
  localparam logic [LEVEL_W-1:0] FAST_L    = LEVEL_W'(FAST_STEP);
  localparam logic [LEVEL_W:0]   HYST_L    = (LEVEL_W+1)'(HYST);
  localparam logic [7:0]         DWELL_L   = 8'(DWELL);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [7:0]         dwell_q, dwell_d;
  logic               changed_q;
  logic               up_q, up_d;

  logic [LEVEL_W-1:0] step;
  logic [LEVEL_W:0]   level_ext, up_thr, dn_thr;
  logic               dwell_ok, promote, demote;

  always_comb begin
    step      = bus.fast ? FAST_L : LEVEL_W'(1);
    level_ext = {1'b0, level_q};
    // Thresholds are one bit wider: the top promotion threshold is 2^LEVEL_W.
    up_thr    = ((LEVEL_W+1)'(stage_q) + (LEVEL_W+1)'(1)) << SEG_W;
    dn_thr    = (LEVEL_W+1)'(stage_q) << SEG_W;
    dwell_ok  = (dwell_q == DWELL_L);
    // Stage decisions look at the registered level, hence the one-cycle lag.
    promote   = (stage_q != STAGE_MAX) && (level_ext >= up_thr) && dwell_ok;
    // level + HYST < stage*SEG avoids an underflowing subtraction.
    demote    = (MONOTONIC == 0) && (stage_q != '0) &&
                ((level_ext + HYST_L) < dn_thr) && dwell_ok;

    level_d = level_q;
    stage_d = stage_q;
    dwell_d = dwell_q;

    if (bus.setval) begin
      // Direct load bypasses hysteresis and dwell; dwell restarts from zero.
      level_d = bus.set_level;
      stage_d = bus.set_level[LEVEL_W-1 -: STAGE_W];
      dwell_d = '0;
    end else if (!bus.freeze) begin
      if (bus.inc && !bus.dec) begin
        level_d = (level_q > (LEVEL_MAX - step)) ? LEVEL_MAX : level_q + step;
      end else if (bus.dec && !bus.inc) begin
        level_d = (level_q < step) ? '0 : level_q - step;
      end

      if (promote) begin
        stage_d = stage_q + STAGE_W'(1);
      end else if (demote) begin
        stage_d = stage_q - STAGE_W'(1);
      end

      if (stage_d != stage_q) begin
        dwell_d = '0;
      end else if (!dwell_ok) begin
        dwell_d = dwell_q + 8'd1;
      end
    end

    up_d = (stage_d != stage_q) ? (stage_d > stage_q) : up_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      stage_q   <= '0;
      dwell_q   <= DWELL_L;  // first change after reset is not delayed
      changed_q <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      level_q   <= level_d;
      stage_q   <= stage_d;
      dwell_q   <= dwell_d;
      changed_q <= (stage_d != stage_q);
      up_q      <= up_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.stage         = stage_q;
  assign bus.stage_changed = changed_q;
  assign bus.stage_up      = up_q;
endmodule

// File: tb/tb_development_stage_tracker.sv
module tb_development_stage_tracker;
  localparam int LW    = 9;
  localparam int SW    = 2;
  localparam int SEG   = 128;
  localparam int MAXL  = 511;
  localparam int NST   = 4;
  localparam int FSTEP = 2;
  localparam int HY    = 8;
  localparam int DW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  development_stage_tracker_if #(.LEVEL_W(LW), .STAGE_W(SW)) bus_n ();
  development_stage_tracker_if #(.LEVEL_W(LW), .STAGE_W(SW)) bus_m ();

  development_stage_tracker #(.LEVEL_W(LW), .STAGE_W(SW), .FAST_STEP(FSTEP),
    .HYST(HY), .DWELL(DW), .MONOTONIC(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
  development_stage_tracker #(.LEVEL_W(LW), .STAGE_W(SW), .FAST_STEP(FSTEP),
    .HYST(HY), .DWELL(DW), .MONOTONIC(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int l0; int s0; int c0; int u0;
    int l1; int s1; int c1; int u1;
  } exp_t;
  exp_t sb[$];

  // Reference model state, index 0 = normal, 1 = monotonic.
  int m_lvl [2];
  int m_st  [2];
  int m_dw  [2];
  int m_chg [2];
  int m_up  [2];

  // Last observed outputs.
  logic [31:0] o_lvl, o_st, o_chg, o_up, mo_lvl, mo_st, mo_chg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input int r, input int inc, input int dec,
                            input int fast, input int setv, input int slv, input int frz);
    int ns, nl, nd, stp;
    if (r != 0) begin
      m_lvl[i] = 0; m_st[i] = 0; m_dw[i] = DW; m_chg[i] = 0; m_up[i] = 0;
      return;
    end
    nl = m_lvl[i]; ns = m_st[i]; nd = m_dw[i];
    stp = (fast != 0) ? FSTEP : 1;
    if (setv != 0) begin
      nl = slv; ns = slv / SEG; nd = 0;
    end else if (frz == 0) begin
      if (inc != 0 && dec == 0) nl = (m_lvl[i] + stp > MAXL) ? MAXL : m_lvl[i] + stp;
      if (dec != 0 && inc == 0) nl = (m_lvl[i] - stp < 0) ? 0 : m_lvl[i] - stp;
      if (m_st[i] < NST-1 && m_lvl[i] >= (m_st[i]+1)*SEG && m_dw[i] == DW)
        ns = m_st[i] + 1;
      else if (i == 0 && m_st[i] > 0 && m_lvl[i] < m_st[i]*SEG - HY && m_dw[i] == DW)
        ns = m_st[i] - 1;
      if (ns != m_st[i]) nd = 0;
      else if (m_dw[i] < DW) nd = m_dw[i] + 1;
    end
    m_chg[i] = (ns != m_st[i]) ? 1 : 0;
    if (ns != m_st[i]) m_up[i] = (ns > m_st[i]) ? 1 : 0;
    m_lvl[i] = nl; m_st[i] = ns; m_dw[i] = nd;
  endtask

  // One clock: drive both DUTs, push model expectation, compare after the edge.
  task automatic cyc(input int r, input int inc, input int dec, input int fast,
                     input int setv, input int slv, input int frz);
    exp_t e;
    exp_t g;
    rst = (r != 0);
    bus_n.inc = (inc != 0); bus_n.dec = (dec != 0); bus_n.fast = (fast != 0);
    bus_n.setval = (setv != 0); bus_n.set_level = LW'(slv); bus_n.freeze = (frz != 0);
    bus_m.inc = (inc != 0); bus_m.dec = (dec != 0); bus_m.fast = (fast != 0);
    bus_m.setval = (setv != 0); bus_m.set_level = LW'(slv); bus_m.freeze = (frz != 0);
    for (int i = 0; i < 2; i++) model_step(i, r, inc, dec, fast, setv, slv, frz);
    e.l0 = m_lvl[0]; e.s0 = m_st[0]; e.c0 = m_chg[0]; e.u0 = m_up[0];
    e.l1 = m_lvl[1]; e.s1 = m_st[1]; e.c1 = m_chg[1]; e.u1 = m_up[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    o_lvl = 32'(bus_n.level); o_st = 32'(bus_n.stage);
    o_chg = 32'(bus_n.stage_changed); o_up = 32'(bus_n.stage_up);
    mo_lvl = 32'(bus_m.level); mo_st = 32'(bus_m.stage); mo_chg = 32'(bus_m.stage_changed);
    g = sb.pop_front();
    chk("sb_level",   o_lvl, g.l0);
    chk("sb_stage",   o_st,  g.s0);
    chk("sb_changed", o_chg, g.c0);
    chk("sb_up",      o_up,  g.u0);
    chk("sb_m_level", mo_lvl, g.l1);
    chk("sb_m_stage", mo_st,  g.s1);
    chk("sb_m_changed", mo_chg, g.c1);
    chk("sb_m_up", 32'(bus_m.stage_up), g.u1);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic setv(input int v);
    cyc(0, 0, 0, 0, 1, v, 0);
  endtask

  initial begin
    // Reset state.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 77, 1);
    chk("rst_level", o_lvl, 0); chk("rst_stage", o_st, 0);
    chk("rst_changed", o_chg, 0); chk("rst_up", o_up, 0);

    // Fast ramp to the first boundary; stage follows one cycle later.
    repeat (64) cyc(0, 1, 0, 1, 0, 0, 0);
    chk("ramp_level128", o_lvl, 128); chk("ramp_stage_lag", o_st, 0);
    idle();
    chk("ramp_stage1", o_st, 1); chk("ramp_pulse", o_chg, 1); chk("ramp_up", o_up, 1);
    idle();
    chk("ramp_pulse_clear", o_chg, 0); chk("ramp_up_held", o_up, 1);

    // Demotion hysteresis: stage 1 holds down to 120, drops after 119.
    setv(130);
    chk("set_same_stage_no_pulse", o_chg, 0); chk("set130_stage", o_st, 1);
    repeat (4) idle();
    repeat (11) cyc(0, 0, 1, 0, 0, 0, 0);
    chk("hyst_level119", o_lvl, 119); chk("hyst_stage_hold", o_st, 1);
    idle();
    chk("hyst_demote", o_st, 0); chk("hyst_pulse", o_chg, 1); chk("hyst_dir_down", o_up, 0);
    chk("mono_no_demote", mo_st, 1);

    // setval jump, then dwell blocking the next promotion.
    setv(300);
    chk("set300_level", o_lvl, 300); chk("set300_stage", o_st, 2);
    chk("set300_pulse", o_chg, 1); chk("set300_up", o_up, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("inc3_level", o_lvl, 303); chk("inc3_stage", o_st, 2); chk("inc3_nopulse", o_chg, 0);
    setv(383);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3) idle();
    chk("dwell_level384", o_lvl, 384); chk("dwell_blocks", o_st, 2);
    idle();
    chk("dwell_promote", o_st, 3); chk("dwell_pulse", o_chg, 1);

    // Freeze holds level, stage and dwell; crossing resolves after unfreeze.
    setv(383);
    chk("set_demote_pulse", o_chg, 1); chk("set_demote_dir", o_up, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 1, 0, 0, 1);
    chk("frz_level", o_lvl, 384); chk("frz_stage", o_st, 2);
    repeat (3) idle();
    chk("frz_dwell_held", o_st, 2);
    idle();
    chk("unfrz_promote", o_st, 3);
    cyc(0, 0, 0, 0, 1, 100, 1);
    chk("set_over_freeze_level", o_lvl, 100); chk("set_over_freeze_stage", o_st, 0);

    // Saturation at both ends.
    setv(511);
    repeat (2) cyc(0, 1, 0, 1, 0, 0, 0);
    chk("sat_top", o_lvl, 511);
    setv(1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("sat_bottom", o_lvl, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("sat_bottom_hold", o_lvl, 0);

    // Monotonic instance never demotes or pulses while draining to zero.
    setv(300);
    repeat (4) idle();
    for (int k = 0; k < 150; k++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      chk("mono_no_pulse", mo_chg, 0);
    end
    repeat (2) idle();
    chk("mono_level0", mo_lvl, 0); chk("mono_stage2", mo_st, 2); chk("norm_stage0", o_st, 0);

    // inc and dec together, fast alone, and reset beating setval.
    setv(200);
    repeat (10) cyc(0, 1, 1, 1, 0, 0, 0);
    chk("incdec_hold", o_lvl, 200);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("fast_alone", o_lvl, 200);
    cyc(1, 1, 0, 1, 1, 400, 1);
    chk("rst_over_set_level", o_lvl, 0); chk("rst_over_set_stage", o_st, 0);
    chk("rst_over_set_changed", o_chg, 0); chk("rst_over_set_m_stage", mo_st, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/development_stage_tracker.md
DEVELOPMENT_STAGE_TRACKER -- requirements
Module: development_stage_tracker

Interface
REQ-001 Parameter LEVEL_W, default 9, level accumulator width.
REQ-002 Parameter STAGE_W, default 2, stage width; STAGE_W < LEVEL_W; SEG = 2^(LEVEL_W-STAGE_W).
REQ-003 Parameter FAST_STEP, default 2, step size when fast=1; 1 <= FAST_STEP < SEG.
REQ-004 Parameter HYST, default 8, demotion hysteresis in level units; 0 <= HYST < SEG.
REQ-005 Parameter DWELL, default 4, minimum cycles between stage changes; 0 to 255.
REQ-006 Parameter MONOTONIC, default 0, value 1 disables demotion.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 inc  input  1  request level increase.
REQ-010 dec  input  1  request level decrease.
REQ-011 fast  input  1  use FAST_STEP instead of 1.
REQ-012 setval  input  1  load set_level.
REQ-013 set_level  input  LEVEL_W  value loaded on setval.
REQ-014 freeze  input  1  hold level, stage and dwell counter.
REQ-015 level  output  LEVEL_W  registered accumulator.
REQ-016 stage  output  STAGE_W  registered development stage.
REQ-017 stage_changed  output  1  one-cycle pulse when stage register changed.
REQ-018 stage_up  output  1  direction of last change (1 promotion, 0 demotion), held between changes.

Function
REQ-019 Level priority per cycle SHALL be: rst > setval > freeze > (inc xor dec) step > hold.
REQ-020 inc=dec=1 without setval SHALL hold level; fast alone SHALL do nothing.
REQ-021 Step SHALL saturate: increase clamps at 2^LEVEL_W-1, decrease clamps at 0; no wrap-around.
REQ-022 Stage SHALL be evaluated on the registered level, so a stage change appears one cycle after the level crossing, one stage per cycle max.
REQ-023 Promotion: stage < 2^STAGE_W-1, level >= (stage+1)*SEG, dwell satisfied -> stage+1.
REQ-024 Demotion: MONOTONIC=0, stage > 0, level < stage*SEG - HYST, dwell satisfied -> stage-1.
REQ-025 Dwell counter SHALL clear on every stage change and count up each non-frozen cycle, saturating at DWELL; dwell satisfied when counter == DWELL (DWELL=0 always satisfied).
REQ-026 setval SHALL, in the same edge, load level=set_level and stage=set_level[LEVEL_W-1:LEVEL_W-STAGE_W] (also when MONOTONIC=1), bypassing hysteresis and dwell, and clear the dwell counter.
REQ-027 stage_changed SHALL be 1 the cycle after any edge where stage register value differed from its previous value, including via setval; stage_up updates the same edge.
REQ-028 setval loading the current stage SHALL NOT pulse stage_changed.
REQ-029 freeze=1 SHALL hold stage and dwell counter; a pending crossing is evaluated on the first unfrozen cycle.
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 rst=1 SHALL set level=0, stage=0, stage_changed=0, stage_up=0, dwell counter=DWELL (first change not delayed).
REQ-032 rst asserted mid-operation SHALL override setval, freeze, inc and dec in the same edge.

Verification (defaults: SEG=128)
REQ-033 After reset, inc=1 fast=1 for 64 cycles -> level=128 on cycle 64, stage=1 and stage_changed=1 on cycle 65, stage_up=1.
REQ-034 level=130 stage=1 dwell satisfied, dec=1 -> stage stays 1 down to level 120, becomes 0 one cycle after level=119.
REQ-035 setval with set_level=300 -> next cycle level=300, stage=2, stage_changed=1; then inc=1 for 3 cycles to 303 -> no change, level=383 crossing next stage blocked until dwell=4 elapsed.
REQ-036 level=511 inc=1 fast=1 -> level stays 511; level=1 dec=1 fast=1 -> level=0.
REQ-037 MONOTONIC=1, stage=2, dec to 0 -> stage stays 2, stage_changed never pulses.
REQ-038 inc=dec=1 for 10 cycles -> level unchanged; rst during setval=1 -> level=0, stage=0.
